button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 76 +++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel two-flop synchronizer followed by a
// counting debouncer. A channel's level only changes after its synchronised
// input has disagreed with the current level for DEBOUNCE_CYCLES consecutive
// clock edges. A one-cycle rise/fall pulse accompanies each accepted change,
// registered so it lines up with the new button_level value.
//
// There is no handshake: button_level is a continuous level, and each
// button_rise / button_fall pulse lasts exactly one clock cycle with no
// back-pressure, so a consumer must sample every cycle.
module button_conditioner #(
    parameter int CHANNELS        = 2,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] button_level,
    output logic [CHANNELS-1:0] button_rise,
    output logic [CHANNELS-1:0] button_fall
);

    // Counter is wide enough to hold DEBOUNCE_CYCLES, although it never
    // goes past DEBOUNCE_CYCLES-1.
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] sync_meta;
    logic [CHANNELS-1:0] sync_s;

    // Two-flop synchronizer; sync_s is the only input the debouncer sees.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_s    <= '0;
        end else begin
            sync_meta <= button_in;
            sync_s    <= sync_meta;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [CW-1:0] count_q;
        logic          level_q;
        logic          rise_q;
        logic          fall_q;

        // Debounce: count consecutive disagreeing edges, clear on any
        // agreement, and accept the new level on the last counted edge.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                count_q <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sync_s[i] == level_q) begin
                    count_q <= '0;
                end else if (count_q == CNT_LAST) begin
                    count_q <= '0;
                    level_q <= sync_s[i];
                    rise_q  <= sync_s[i];
                    fall_q  <= ~sync_s[i];
                end else begin
                    count_q <= count_q + CW'(1);
                end
            end
        end

        assign button_level[i] = level_q;
        assign button_rise[i]  = rise_q;
        assign button_fall[i]  = fall_q;
    end

endmodule
